// File: rtl/bcd_event_sequencer.sv
// Digit-serial 3-digit packed-BCD event counter: load handshake, one-deep event buffer, sticky errors.
// Optional macro BCD_SATURATE_EN: hold at MAX_BCD instead of wrapping 999 -> 000.
module bcd_event_sequencer #(
    parameter logic [11:0] MAX_BCD = 12'h999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [11:0] load_bcd,
    input  logic        start,
    input  logic        stop,
    input  logic        evt,
    output logic [11:0] count,
    output logic        busy,
    output logic        tc,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {IDLE, RUN, D0, D1, D2} state_e;

`ifdef BCD_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic        tc_q, tc_d;
    logic [1:0]  err_q, err_d;
    logic        pend_q, pend_d;
    logic        stop_q, stop_d;

    logic [3:0]  digit, digit_eff, new_digit;
    logic [11:0] count_inc;
    logic        carry, done, load_illegal, saturated, sat_hit;
    logic        pend_now, stop_now;

    assign load_illegal = (load_bcd[11:8] > 4'd9) || (load_bcd[7:4] > 4'd9) ||
                          (load_bcd[3:0] > 4'd9);
    assign saturated    = SAT_EN && (count_q == MAX_BCD);
    assign sat_hit      = SAT_EN && (count_inc == MAX_BCD);

    // One digit is processed per D state; an illegal digit behaves as 9 and carries.
    always_comb begin
        digit = count_q[3:0];
        case (state_q)
            D1:      digit = count_q[7:4];
            D2:      digit = count_q[11:8];
            default: digit = count_q[3:0];
        endcase
        digit_eff = (digit > 4'd9) ? 4'd9 : digit;
        carry     = (digit_eff == 4'd9);
        new_digit = carry ? 4'd0 : digit_eff + 4'd1;
        count_inc = count_q;
        case (state_q)
            D1:      count_inc[7:4]  = new_digit;
            D2:      count_inc[11:8] = new_digit;
            default: count_inc[3:0]  = new_digit;
        endcase
        done = !carry || (state_q == D2);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
        err_d    = err_q;
        pend_d   = pend_q;
        stop_d   = stop_q;
        pend_now = pend_q | evt;
        stop_now = stop_q | stop;

        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                stop_d = 1'b0;
                if (load_valid) begin
                    count_d = load_bcd;
                    err_d   = {1'b0, load_illegal};
                end
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                if (stop)                   state_d = IDLE;
                else if (evt && !saturated) state_d = D0;
            end
            D0, D1, D2: begin
                count_d = count_inc;
                if (pend_q && evt && !(done && sat_hit)) err_d[1] = 1'b1;
                if (done) begin
                    tc_d   = (count_inc == MAX_BCD);
                    pend_d = 1'b0;
                    stop_d = 1'b0;
                    if (stop_now)                 state_d = IDLE;
                    else if (pend_now && !sat_hit) state_d = D0;
                    else                          state_d = RUN;
                end else begin
                    pend_d  = pend_now;
                    stop_d  = stop_now;
                    state_d = (state_q == D0) ? D1 : D2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 12'h000;
            tc_q    <= 1'b0;
            err_q   <= 2'b00;
            pend_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            stop_q  <= stop_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == D0) || (state_q == D1) || (state_q == D2);
    assign count      = count_q;
    assign tc         = tc_q;
    assign err        = err_q;

endmodule
